dmem_responder: RTL

- Target-side data memory for the core's load/store port; receives access requests and answers them.
- Holds one outstanding request, inserts a configurable number of wait states, performs byte-lane writes and aligned, sign/zero-extended reads.
- Returns an error response for misaligned, out-of-range or reserved-size accesses.
- Sits between the core's MEM stage and on-chip SRAM, replacing the fixed-latency data memory model.

---
 rtl/dmem_responder_pkg.sv | 5 +
 rtl/dmem_responder_load_align.sv | 20 ++
 rtl/dmem_responder.sv | 98 +++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: access-size and responder-state types shared by the data memory path
package dmem_responder_pkg;
  typedef enum logic [1:0] {MEM_BYTE = 2'b00, MEM_HALF = 2'b01, MEM_WORD = 2'b10} mem_size_t;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
endpackage

// File: rtl/dmem_responder_load_align.sv
// load_align: selects the addressed byte/half of a word and sign- or zero-extends it
module load_align
  import dmem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{addr, 3'b000} +: 8];
    h = addr[1] ? word[31:16] : word[15:0];
    data = size == MEM_BYTE ? {{24{b[7] & ~is_unsigned}}, b} :
           size == MEM_HALF ? {{16{h[15] & ~is_unsigned}}, h} :
           size == MEM_WORD ? word : '0;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data memory target with wait states, byte-lane stores and error responses
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);
  localparam int AW = $clog2(DEPTH_WORDS);
  dmem_state_t   state;
  logic [2:0]    cnt;
  logic [31:0]   addr, wdata, wrep, ld;
  logic [1:0]    size;
  logic          write, is_unsigned, err, commit;
  logic [3:0]    be;
  logic [AW-1:0] idx;
  logic [31:0]   mem [DEPTH_WORDS];
  always_comb begin
    idx = addr[AW+1:2];
    err = size == 2'b11 || (size == MEM_HALF && addr[0]) ||
          (size == MEM_WORD && addr[1:0] != 2'b00) || addr[31:AW+2] != '0;
    be = size == MEM_BYTE ? 4'b0001 << addr[1:0] :
         size == MEM_HALF ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wrep = size == MEM_BYTE ? {4{wdata[7:0]}} :
           size == MEM_HALF ? {2{wdata[15:0]}} : wdata;
    commit = state == WAIT && cnt == 3'd0;
  end
  load_align u_align (
    .word(mem[idx]),
    .addr(addr[1:0]),
    .size(size),
    .is_unsigned(is_unsigned),
    .data(ld)
  );
  // commit edge: the same edge that enters RESP writes the SRAM and samples the read
  always_ff @(posedge clk)
    if (commit && write && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      addr <= '0;
      wdata <= '0;
      size <= '0;
      write <= 1'b0;
      is_unsigned <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (req_valid && req_ready) begin
            addr <= req_addr;
            wdata <= req_wdata;
            size <= req_size;
            write <= req_write;
            is_unsigned <= req_unsigned;
            cnt <= 3'(WAIT_CYCLES);
            state <= WAIT;
            req_ready <= 1'b0;
          end else req_ready <= 1'b1;
        WAIT:
          if (!commit) cnt <= cnt - 3'd1;
          else begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= err || write ? '0 : ld;
            rsp_error <= err;
          end
        RESP:
          if (rsp_ready) begin
            state <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            req_ready <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
